reg_signoff_monitor: RTL and testbench

- Synthesizable end-of-test checker sitting directly downstream of cpu_top.
- Consumes the writeback-stage write port and the debug register-file read port.
- Detects the test-complete write (x11 = 0x0000C0DE) or a cycle timeout, then scans all 32 architectural registers against an expected-value ROM.
- Reports pass/fail, mismatch count and first failing register, so sign-off runs in hardware or on FPGA without file I/O.

---
 rtl/cpu_test_pkg.sv | 31 +++
 rtl/reg_signoff_monitor_if.sv | 47 ++++
 rtl/reg_signoff_monitor_scan_cmp.sv | 83 ++++++++
 rtl/reg_signoff_monitor.sv | 121 ++++++++++++
 tb/tb_reg_signoff_monitor.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_test_pkg.sv
// ============================================================================
// Module      : cpu_test_pkg
// Description : Shared FSM states, end-of-test defaults and signature helper.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package cpu_test_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int unsigned C_MAGIC_REG   = 11;
    localparam logic [31:0] C_MAGIC_VAL   = 32'h0000_C0DE;
    localparam int unsigned C_TIMEOUT_CYC = 50;
    localparam int unsigned C_NUM_REGS    = 32;

    // Commit-order signature step: rotate left by one, fold in data and index.
    function automatic logic [31:0] sig_next(input logic [31:0] sig,
                                             input logic [4:0]  rd,
                                             input logic [31:0] wdata);
        return {sig[30:0], sig[31]} ^ wdata ^ {27'b0, rd};
    endfunction

endpackage

`default_nettype wire

// File: rtl/reg_signoff_monitor_if.sv
// ============================================================================
// Module      : reg_signoff_monitor_if
// Description : Writeback, debug-read, ROM and result signals of the monitor.
//               Optional sig output exists when REG_SIGNOFF_SIG_HASH_EN is set.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface reg_signoff_monitor_if;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_wdata;
    logic [4:0]  reg_raddr;
    logic [31:0] reg_rdata;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic        halt_req;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [5:0]  mismatch_cnt;
    logic [4:0]  first_bad;
    logic [31:0] cycle_cnt;
`ifdef REG_SIGNOFF_SIG_HASH_EN
    logic [31:0] sig;
`endif

    modport master (
`ifdef REG_SIGNOFF_SIG_HASH_EN
        input  sig,
`endif
        output wb_we, wb_rd, wb_wdata, reg_rdata, exp_data,
        input  reg_raddr, exp_addr, halt_req, done, pass, timeout,
               mismatch_cnt, first_bad, cycle_cnt
    );

    modport slave (
`ifdef REG_SIGNOFF_SIG_HASH_EN
        output sig,
`endif
        input  wb_we, wb_rd, wb_wdata, reg_rdata, exp_data,
        output reg_raddr, exp_addr, halt_req, done, pass, timeout,
               mismatch_cnt, first_bad, cycle_cnt
    );
endinterface

`default_nettype wire

// File: rtl/reg_signoff_monitor_scan_cmp.sv
// ============================================================================
// Module      : reg_scan_cmp
// Description : Register scan sequencer, read-data alignment, comparator,
//               saturating mismatch counter and first-failure capture.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module reg_scan_cmp
    import cpu_test_pkg::*;
#(
    parameter int unsigned NUM_REGS = C_NUM_REGS
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        i_start,
    input  wire logic [31:0] i_rdata,
    input  wire logic [31:0] i_exp_data,
    output logic [4:0]       o_addr,
    output logic             o_issue_last,
    output logic             o_done,
    output logic [5:0]       o_mismatch_cnt,
    output logic [4:0]       o_first_bad
);

    localparam logic [4:0] C_LAST    = 5'(NUM_REGS - 1);
    localparam logic [5:0] C_CNT_MAX = 6'(NUM_REGS);

    logic        r_issuing;
    logic        r_cmp_valid;
    logic [4:0]  r_idx;
    logic [4:0]  r_cmp_idx;
    logic [31:0] r_rdata;
    logic [5:0]  r_cnt;
    logic [4:0]  r_first;
    logic        w_mismatch;

    // Register data is delayed one cycle so it lines up with the ROM output.
    assign w_mismatch = r_cmp_valid && (r_rdata != i_exp_data);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_issuing   <= 1'b0;
            r_cmp_valid <= 1'b0;
            r_idx       <= '0;
            r_cmp_idx   <= '0;
            r_rdata     <= '0;
            r_cnt       <= '0;
            r_first     <= '0;
        end else begin
            r_cmp_valid <= r_issuing;
            r_cmp_idx   <= r_idx;
            r_rdata     <= i_rdata;
            if (i_start) begin
                r_issuing <= 1'b1;
                r_idx     <= '0;
            end else if (r_issuing) begin
                if (r_idx == C_LAST) begin
                    r_issuing <= 1'b0;
                end else begin
                    r_idx <= r_idx + 5'd1;
                end
            end
            if (w_mismatch) begin
                if (r_cnt != C_CNT_MAX) begin
                    r_cnt <= r_cnt + 6'd1;
                end
                if (r_cnt == 6'd0) begin
                    r_first <= r_cmp_idx;
                end
            end
        end
    end

    assign o_addr         = r_idx;
    assign o_issue_last   = r_issuing && (r_idx == C_LAST);
    assign o_done         = r_cmp_valid && (r_cmp_idx == C_LAST);
    assign o_mismatch_cnt = r_cnt;
    assign o_first_bad    = r_first;

endmodule

`default_nettype wire

// File: rtl/reg_signoff_monitor.sv
// ============================================================================
// Module      : reg_signoff_monitor
// Description : End-of-test checker: RUN/timeout FSM, halt request and result
//               reporting. REG_SIGNOFF_SIG_HASH_EN adds a commit signature.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module reg_signoff_monitor
    import cpu_test_pkg::*;
#(
    parameter int unsigned MAGIC_REG   = C_MAGIC_REG,
    parameter logic [31:0] MAGIC_VAL   = C_MAGIC_VAL,
    parameter int unsigned TIMEOUT_CYC = C_TIMEOUT_CYC,
    parameter int unsigned NUM_REGS    = C_NUM_REGS
) (
    input  wire logic            clk,
    input  wire logic            reset,
    reg_signoff_monitor_if.slave bus
);

    localparam logic [4:0]  C_MAGIC_RD = 5'(MAGIC_REG);
    localparam logic [31:0] C_TO_LAST  = 32'(TIMEOUT_CYC - 1);

    state_e      r_state;
    state_e      w_state_nxt;
    logic [31:0] r_cycle_cnt;
    logic        r_timeout;
    logic        w_magic;
    logic        w_scan_start;
    logic        w_timeout_set;
    logic        w_issue_last;
    logic        w_scan_done;
    logic [4:0]  w_addr;
    logic [5:0]  w_mismatch_cnt;
    logic [4:0]  w_first_bad;

    // x0 writes never count as the end-of-test marker.
    assign w_magic = bus.wb_we && (bus.wb_rd != 5'd0) &&
                     (bus.wb_rd == C_MAGIC_RD) && (bus.wb_wdata == MAGIC_VAL);

    always_comb begin
        w_state_nxt   = r_state;
        w_scan_start  = 1'b0;
        w_timeout_set = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_magic) begin
                    w_state_nxt  = ST_SCAN;
                    w_scan_start = 1'b1;
                end else if (r_cycle_cnt == C_TO_LAST) begin
                    w_state_nxt   = ST_SCAN;
                    w_scan_start  = 1'b1;
                    w_timeout_set = 1'b1;
                end
            end
            ST_SCAN:  if (w_issue_last) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_scan_done)  w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_DONE;
            default:  w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_cycle_cnt <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_RUN) begin
                r_cycle_cnt <= r_cycle_cnt + 32'd1;
            end
            if (w_timeout_set) begin
                r_timeout <= 1'b1;
            end
        end
    end

    reg_scan_cmp #(
        .NUM_REGS (NUM_REGS)
    ) u_scan_cmp (
        .clk            (clk),
        .reset          (reset),
        .i_start        (w_scan_start),
        .i_rdata        (bus.reg_rdata),
        .i_exp_data     (bus.exp_data),
        .o_addr         (w_addr),
        .o_issue_last   (w_issue_last),
        .o_done         (w_scan_done),
        .o_mismatch_cnt (w_mismatch_cnt),
        .o_first_bad    (w_first_bad)
    );

    assign bus.reg_raddr    = w_addr;
    assign bus.exp_addr     = w_addr;
    assign bus.halt_req     = (r_state != ST_RUN);
    assign bus.done         = (r_state == ST_DONE);
    assign bus.pass         = (r_state == ST_DONE) && (w_mismatch_cnt == 6'd0) && !r_timeout;
    assign bus.timeout      = r_timeout;
    assign bus.mismatch_cnt = w_mismatch_cnt;
    assign bus.first_bad    = w_first_bad;
    assign bus.cycle_cnt    = r_cycle_cnt;

`ifdef REG_SIGNOFF_SIG_HASH_EN
    logic [31:0] r_sig;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sig <= '0;
        end else if ((r_state == ST_RUN) && bus.wb_we && (bus.wb_rd != 5'd0)) begin
            r_sig <= sig_next(r_sig, bus.wb_rd, bus.wb_wdata);
        end
    end

    assign bus.sig = r_sig;
`endif

endmodule

`default_nettype wire

// File: tb/tb_reg_signoff_monitor.sv
// ============================================================================
// Module      : tb_reg_signoff_monitor
// Description : Self-checking bench: table vectors, random scenarios against
//               a behavioural model, mid-scan reset and optional signature.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_reg_signoff_monitor;

    localparam logic [31:0] MAGIC = 32'h0000_C0DE;

    typedef struct {
        int          magic_at;
        int          magic_rd;
        logic [31:0] cmask;
        bit          e_timeout;
        int          e_cycle;
        int          e_cnt;
        int          e_first;
        bit          e_pass;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] regs [32];
    logic [31:0] rom  [32];
    int          n_chk = 0;
    int          n_err = 0;

    reg_signoff_monitor_if bus ();

    reg_signoff_monitor dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.reg_rdata = regs[bus.reg_raddr];

    always @(posedge clk) bus.exp_data <= rom[bus.exp_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctrl"}, {28'b0, bus.halt_req, bus.done, bus.pass, bus.timeout}, 32'h0);
        check({tag, "_res"}, {16'b0, 1'b0, bus.mismatch_cnt, bus.first_bad, bus.reg_raddr}, 32'h0);
        check({tag, "_eaddr"}, {27'b0, bus.exp_addr}, 32'h0);
        check({tag, "_cyc"}, bus.cycle_cnt, 32'h0);
`ifdef REG_SIGNOFF_SIG_HASH_EN
        check({tag, "_sig"}, bus.sig, 32'h0);
`endif
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.wb_we    = 1'b0;
        bus.wb_rd    = '0;
        bus.wb_wdata = '0;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Non-marker write traffic.
    task automatic drive_random();
        bus.wb_we    = 1'($urandom_range(0, 1));
        bus.wb_rd    = 5'($urandom_range(0, 31));
        bus.wb_wdata = $urandom;
        if (bus.wb_rd == 5'd11 && bus.wb_wdata == MAGIC) bus.wb_wdata ^= 32'h1;
    endtask

    function automatic logic [31:0] sig_model(input logic [31:0] s, input logic [4:0] rd,
                                              input logic [31:0] d);
        logic [31:0] rot;
        rot = (s << 1) | (s >> 31);
        return rot ^ d ^ 32'(rd);
    endfunction

    // Outcome predicted purely from the end-of-test rules.
    function automatic vec_t model(input int magic_at, input int magic_rd, input logic [31:0] cmask);
        vec_t v;
        bit   trig;
        v.magic_at = magic_at;
        v.magic_rd = magic_rd;
        v.cmask    = cmask;
        trig       = (magic_rd == 11) && (magic_at >= 0) && (magic_at <= 49);
        v.e_timeout = !trig;
        v.e_cycle   = trig ? magic_at + 1 : 50;
        v.e_cnt     = $countones(cmask);
        v.e_first   = 0;
        for (int i = 31; i >= 0; i--) if (cmask[i]) v.e_first = i;
        v.e_pass    = (v.e_cnt == 0) && trig;
        return v;
    endfunction

    task automatic load_data(input logic [31:0] cmask);
        for (int i = 0; i < 32; i++) begin
            regs[i] = (i == 0) ? 32'h0 : $urandom;
            rom[i]  = regs[i];
            if (cmask[i]) rom[i] = regs[i] ^ (32'h1 << $urandom_range(0, 31));
        end
    endtask

    task automatic run_scenario(input string tag, input vec_t v, input bit skip_reset);
        int          c;
        int          k;
        bit          halted;
        logic [31:0] sig_m;
        load_data(v.cmask);
        if (!skip_reset) begin
            do_reset();
            check_zero({tag, "_rst"});
        end
        c      = 0;
        halted = 0;
        sig_m  = 32'h0;
        while (!halted && c <= 60) begin
            if (c == v.magic_at) begin
                bus.wb_we    = 1'b1;
                bus.wb_rd    = 5'(v.magic_rd);
                bus.wb_wdata = MAGIC;
            end else begin
                drive_random();
            end
            if (bus.wb_we && bus.wb_rd != 5'd0) sig_m = sig_model(sig_m, bus.wb_rd, bus.wb_wdata);
            @(posedge clk);
            #1;
            if (bus.halt_req) halted = 1;
            else c++;
        end
        if (!halted) begin
            check({tag, "_halt_seen"}, 32'h0, 32'h1);
            return;
        end
        check({tag, "_scan_entry"}, c, v.e_cycle - 1);
        check({tag, "_cyc_entry"}, bus.cycle_cnt, v.e_cycle);
        check({tag, "_timeout"}, {31'b0, bus.timeout}, {31'b0, v.e_timeout});
        k = 0;
        while (!bus.done && k < 40) begin
            drive_random();
            @(posedge clk);
            #1;
            k++;
        end
        bus.wb_we = 1'b0;
        check({tag, "_done_lat"}, k, 33);
        check({tag, "_mcnt"}, {26'b0, bus.mismatch_cnt}, v.e_cnt);
        if (v.e_cnt != 0) check({tag, "_first"}, {27'b0, bus.first_bad}, v.e_first);
        check({tag, "_pass"}, {31'b0, bus.pass}, {31'b0, v.e_pass});
        check({tag, "_cyc_hold"}, bus.cycle_cnt, v.e_cycle);
        check({tag, "_halt"}, {31'b0, bus.halt_req}, 32'h1);
        check({tag, "_addr_hold"}, {27'b0, bus.reg_raddr}, 32'd31);
`ifdef REG_SIGNOFF_SIG_HASH_EN
        check({tag, "_sig"}, bus.sig, sig_m);
`endif
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_sticky"}, {26'b0, bus.done, bus.pass, bus.mismatch_cnt},
              {26'b0, 1'b1, v.e_pass, 6'(v.e_cnt)});
    endtask

    initial begin
        vec_t vt [8];
        vec_t vr;
        vt[0] = '{magic_at: 10, magic_rd: 11, cmask: 32'h0,                        e_timeout: 0, e_cycle: 11, e_cnt: 0,  e_first: 0, e_pass: 1};
        vt[1] = '{magic_at: 10, magic_rd: 11, cmask: (32'h1 << 5) | (32'h1 << 20), e_timeout: 0, e_cycle: 11, e_cnt: 2,  e_first: 5, e_pass: 0};
        vt[2] = '{magic_at: -1, magic_rd: 11, cmask: 32'h0,                        e_timeout: 1, e_cycle: 50, e_cnt: 0,  e_first: 0, e_pass: 0};
        vt[3] = '{magic_at: 49, magic_rd: 11, cmask: 32'h0,                        e_timeout: 0, e_cycle: 50, e_cnt: 0,  e_first: 0, e_pass: 1};
        vt[4] = '{magic_at: 10, magic_rd: 12, cmask: 32'h0,                        e_timeout: 1, e_cycle: 50, e_cnt: 0,  e_first: 0, e_pass: 0};
        vt[5] = '{magic_at: 10, magic_rd: 0,  cmask: 32'h0,                        e_timeout: 1, e_cycle: 50, e_cnt: 0,  e_first: 0, e_pass: 0};
        vt[6] = '{magic_at: 0,  magic_rd: 11, cmask: 32'h8000_0001,                e_timeout: 0, e_cycle: 1,  e_cnt: 2,  e_first: 0, e_pass: 0};
        vt[7] = '{magic_at: 20, magic_rd: 11, cmask: 32'hFFFF_FFFF,                e_timeout: 0, e_cycle: 21, e_cnt: 32, e_first: 0, e_pass: 0};

        for (int i = 0; i < 8; i++) run_scenario($sformatf("vec%0d", i), vt[i], 1'b0);

        for (int i = 0; i < 6; i++) begin
            int          rd_sel;
            logic [31:0] m;
            rd_sel = $urandom_range(0, 3);
            m      = ($urandom_range(0, 2) == 0) ? 32'h0 : ($urandom & $urandom);
            vr = model($urandom_range(0, 60), (rd_sel == 2) ? 12 : (rd_sel == 3) ? 0 : 11, m);
            run_scenario($sformatf("rnd%0d", i), vr, 1'b0);
        end

        // Reset in the middle of a scan, then a clean full scan.
        load_data(32'h0);
        do_reset();
        bus.wb_we    = 1'b1;
        bus.wb_rd    = 5'd11;
        bus.wb_wdata = MAGIC;
        @(posedge clk);
        #1 bus.wb_we = 1'b0;
        check("mid_halt", {31'b0, bus.halt_req}, 32'h1);
        repeat (17) @(posedge clk);
        #1;
        check("mid_idx17", {27'b0, bus.reg_raddr}, 32'd17);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check_zero("mid_rst");
        run_scenario("post_rst", model(3, 11, 32'h0000_0400), 1'b1);

`ifdef REG_SIGNOFF_SIG_HASH_EN
        do_reset();
        bus.wb_we = 1'b1; bus.wb_rd = 5'd1; bus.wb_wdata = 32'h1;
        @(posedge clk); #1;
        check("sig_w1", bus.sig, 32'h0);
        bus.wb_rd = 5'd2; bus.wb_wdata = 32'h2;
        @(posedge clk); #1;
        check("sig_w2", bus.sig, 32'h0);
        bus.wb_rd = 5'd3; bus.wb_wdata = 32'h10;
        @(posedge clk); #1;
        check("sig_w3", bus.sig, 32'h13);
        bus.wb_rd = 5'd0; bus.wb_wdata = 32'hFFFF;
        @(posedge clk); #1;
        check("sig_x0", bus.sig, 32'h13);
        bus.wb_we = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
